// File: rtl/led_pwm_dimmer.sv
// ---------------------------------------------------------------------------
// led_pwm_dimmer
//
// Dims and optionally blinks a 16-bit LED pattern with a free-running
// 16-step PWM. A prescaler divides clk into PWM ticks. Sixteen ticks make one
// PWM period. The LED pattern and the brightness/blink configuration are only
// taken up at period boundaries, so a period is never torn mid-way.
//
// Parameters
//   PRESCALE       clk cycles per PWM tick (2..65535)
//   BLINK_PERIODS  PWM periods per blink half-cycle (1..65535)
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-low reset
//   led_data      in   [15:0] LED pattern from the upstream register stage
//   cfg_we        in   single-cycle configuration write strobe
//   cfg_data      in   [31:0] config: [3:0] brightness, [4] blink enable
//   led_out       out  [15:0] registered dimmed/blinked LED drive
//   period_start  out  registered pulse on the first cycle of each period
//
// Handshake: cfg_we is a fire-and-forget strobe with no ready. Every cycle
// with cfg_we high is accepted, and the last write before a boundary wins.
// ---------------------------------------------------------------------------
module led_pwm_dimmer #(
  parameter int PRESCALE      = 1000,
  parameter int BLINK_PERIODS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] led_data,
  input  logic        cfg_we,
  input  logic [31:0] cfg_data,
  output logic [15:0] led_out,
  output logic        period_start
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_PERIODS - 1);

  logic [15:0] presc_q, presc_d;
  logic [3:0]  pwm_cnt_q, pwm_cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  pend_bright_q, pend_bright_d;
  logic        pend_blink_q, pend_blink_d;
  logic [3:0]  bright_q, bright_d;
  logic        blink_en_q, blink_en_d;
  logic [15:0] per_cnt_q, per_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [15:0] led_out_q, led_out_d;
  logic        period_start_q, period_start_d;

  logic tick;
  logic boundary;
  logic duty_d;

  // Upper configuration bits are reserved and deliberately ignored.
  logic unused_cfg;
  assign unused_cfg = ^cfg_data[31:5];

  always_comb begin
    tick           = (presc_q == PRESC_LAST);
    boundary       = tick && (pwm_cnt_q == 4'hF);

    presc_d        = tick ? '0 : presc_q + 16'd1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 4'd1 : pwm_cnt_q;
    shadow_d       = boundary ? led_data : shadow_q;

    pend_bright_d  = pend_bright_q;
    pend_blink_d   = pend_blink_q;
    if (cfg_we) begin
      pend_bright_d = cfg_data[3:0];
      pend_blink_d  = cfg_data[4];
    end

    // Taking the pending *next* value means a write landing on the boundary
    // cycle is applied to the very next period.
    bright_d       = boundary ? pend_bright_d : bright_q;
    blink_en_d     = boundary ? pend_blink_d  : blink_en_q;

    // Disabling blink forces the phase on immediately. Counting only starts
    // once blink has been active for a full period, so the first blink
    // half-cycle after enabling is a full BLINK_PERIODS long.
    per_cnt_d      = per_cnt_q;
    blink_phase_d  = blink_phase_q;
    if (!blink_en_d) begin
      per_cnt_d     = '0;
      blink_phase_d = 1'b1;
    end else if (boundary && blink_en_q) begin
      if (per_cnt_q == BLINK_LAST) begin
        per_cnt_d     = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        per_cnt_d     = per_cnt_q + 16'd1;
      end
    end

    // The output is built from next-state values. This keeps it aligned with
    // the counters it reflects, so period_start coincides with pwm_cnt==0.
    duty_d         = (bright_d == 4'hF) || (pwm_cnt_d < bright_d);
    led_out_d      = shadow_d & {16{duty_d & blink_phase_d}};
    period_start_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q        <= '0;
      pwm_cnt_q      <= '0;
      shadow_q       <= '0;
      pend_bright_q  <= 4'hF;
      pend_blink_q   <= 1'b0;
      bright_q       <= 4'hF;
      blink_en_q     <= 1'b0;
      per_cnt_q      <= '0;
      blink_phase_q  <= 1'b1;
      led_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      pwm_cnt_q      <= pwm_cnt_d;
      shadow_q       <= shadow_d;
      pend_bright_q  <= pend_bright_d;
      pend_blink_q   <= pend_blink_d;
      bright_q       <= bright_d;
      blink_en_q     <= blink_en_d;
      per_cnt_q      <= per_cnt_d;
      blink_phase_q  <= blink_phase_d;
      led_out_q      <= led_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign led_out      = led_out_q;
  assign period_start = period_start_q;

endmodule

// File: doc/led_pwm_dimmer.md
LED_PWM_DIMMER -- requirements
Module: led_pwm_dimmer

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 1000: clk cycles per PWM tick, legal range 2..65535.
REQ-002 The block SHALL have parameter BLINK_PERIODS, default 256: PWM periods per blink half-cycle, legal range 1..65535.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: reset is synchronous and active-low.
REQ-005 Port led_data  input  16: LED pattern from the upstream Led register stage.
REQ-006 Port cfg_we  input  1: single-cycle configuration write strobe.
REQ-007 Port cfg_data  input  32: configuration word; [3:0] brightness, [4] blink enable, [31:5] ignored.
REQ-008 Port led_out  output  16: registered, dimmed and blinked drive to the board LEDs.
REQ-009 Port period_start  output  1: registered one-cycle pulse marking the first cycle of each PWM period.

Function
REQ-010 The prescaler SHALL count 0..PRESCALE-1 and wrap to 0; tick SHALL be asserted in the cycle where prescaler==PRESCALE-1.
REQ-011 The 4-bit pwm_cnt SHALL increment on tick and wrap 15->0; PWM period SHALL be 16*PRESCALE cycles.
REQ-012 Boundary SHALL be defined as tick with pwm_cnt==15.
REQ-013 On boundary, the shadow pattern register SHALL load led_data; between boundaries led_data changes SHALL NOT affect led_out.
REQ-014 cfg_we SHALL load cfg_data[4:0] into the pending config register; a later cfg_we before a boundary SHALL overwrite it (last write wins).
REQ-015 On boundary, the active brightness/blink registers SHALL load the pending value; if cfg_we coincides with boundary, cfg_data SHALL load directly into active and pending.
REQ-016 Duty SHALL be on when bright==15, off when bright==0, otherwise on iff pwm_cnt < bright.
REQ-017 Blink disabled: blink_phase SHALL be forced to 1 and the period counter SHALL be held at 0.
REQ-018 Blink enabled: the period counter SHALL increment on boundary; on reaching BLINK_PERIODS-1 at a boundary it SHALL clear and blink_phase SHALL toggle.
REQ-019 led_out SHALL equal, registered one cycle after the counter state, shadow & {16{duty & blink_phase}}.
REQ-020 period_start SHALL assert in the cycle after boundary, i.e. concurrently with led_out reflecting pwm_cnt==0.
REQ-021 Counters SHALL run freely; no input SHALL stall or restart the prescaler or pwm_cnt.

Reset
REQ-022 In a cycle with rst==0, on the rising edge: prescaler, pwm_cnt, period counter, shadow, led_out, period_start SHALL be 0.
REQ-023 In the same reset cycle, pending and active brightness SHALL become 15 and blink enable 0.
REQ-024 In the same reset cycle, blink_phase SHALL become 1.
REQ-025 Reset asserted mid-period SHALL take priority over cfg_we and boundary in that cycle.
REQ-026 After release, the first boundary SHALL occur 16*PRESCALE cycles later, and led_out SHALL stay 0 until then.

Verification (PRESCALE=2, BLINK_PERIODS=2, period 32 cycles)
REQ-027 Reset, led_data=16'hA5A5, no cfg -> led_out=0 for 32 cycles, then 16'hA5A5 constantly; period_start pulses every 32 cycles.
REQ-028 cfg_we with cfg_data=4 -> from next boundary led_out=16'hA5A5 for 8 cycles, 0 for 24 cycles, each period.
REQ-029 cfg_data=0 -> led_out=0 continuously; cfg_data=15 -> 16'hA5A5 continuously, with no off cycles.
REQ-030 led_data changes mid-period 16'hA5A5->16'h00FF -> led_out unchanged until next period_start, then 16'h00FF.
REQ-031 cfg_data=5'b1_1111 -> led_out alternates two periods of pattern and two periods of 0; clearing blink restores steady on at the next boundary.
REQ-032 cfg_we in the boundary cycle with 2, and rst=0 mid-period -> brightness 2 is applied to the immediately following period; reset then forces led_out=0 and config to 15/0.
